// File: rtl/tl_pkg.sv
// TileLink E-channel types shared by the sink router and its testbench.
// tl_e_t : one E-channel beat (grant acknowledge), carrying the sink id.
package tl_pkg;

    localparam int unsigned SinkW = 8;

    typedef struct packed {
        logic [SinkW-1:0] sink;
    } tl_e_t;

endpackage

// File: rtl/tl_spill_reg.sv
// Two-entry valid/ready spill stage for an arbitrary packed payload type.
// Ports:
//   clk_i, rst_i       : clock, synchronous active-low reset
//   valid_i/ready_o    : upstream handshake (ready_o is a flop, no path from ready_i)
//   data_i             : upstream payload
//   valid_o/ready_i    : downstream handshake
//   data_o             : head entry, held stable until popped
module tl_spill_reg #(
    parameter type T = logic
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic valid_i,
    output logic ready_o,
    input  T     data_i,
    output logic valid_o,
    input  logic ready_i,
    output T     data_o
);

    T           mem_q [2];
    logic       wr_ptr_q, wr_ptr_d;
    logic       rd_ptr_q, rd_ptr_d;
    logic [1:0] cnt_q, cnt_d;
    logic       ready_q, ready_d;
    logic       push, pop;

    assign push    = valid_i & ready_q;
    assign pop     = valid_o & ready_i;
    assign valid_o = (cnt_q != 2'd0);
    assign data_o  = mem_q[rd_ptr_q];
    assign ready_o = ready_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q ^ push;
        rd_ptr_d = rd_ptr_q ^ pop;
        cnt_d    = cnt_q + {1'b0, push} - {1'b0, pop};
        // Ready is registered from the next occupancy so a simultaneous
        // push and pop at one entry keeps full throughput.
        ready_d  = (cnt_d != 2'd2);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            cnt_q    <= 2'd0;
            ready_q  <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
            ready_q  <= ready_d;
        end
    end

    // Payload storage needs no reset; occupancy alone qualifies it.
    always_ff @(posedge clk_i) begin
        if (push) begin
            mem_q[wr_ptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/tl_sink_router_e.sv
// Routes TileLink E-channel beats to one of SLAVE_NUM slaves by a sink bit field.
// Ports:
//   clk_i, rst_i            : clock, synchronous active-low reset
//   e_valid_i/e_ready_o     : upstream handshake, e_bits_i upstream beat
//   e_valid_o (one-hot)     : per-slave valid, e_ready_i per-slave ready
//   e_bits_o                : beat broadcast to all slaves
//   err_o, drop_cnt_o       : sticky unmapped flag and saturating unmapped count
//   err_clr_i               : clears err_o and drop_cnt_o (wins over a same-cycle event)
module tl_sink_router_e
    import tl_pkg::*;
#(
    parameter int unsigned SLAVE_NUM     = 8,
    parameter int unsigned SINK_LSB      = 2,
    parameter int unsigned SINK_MSB      = 5,
    parameter int unsigned PIPE          = 1,
    parameter int unsigned DROP_UNMAPPED = 1,
    parameter type         DATA_T        = tl_e_t
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 e_valid_i,
    output logic                 e_ready_o,
    input  DATA_T                e_bits_i,
    output logic [SLAVE_NUM-1:0] e_valid_o,
    input  logic [SLAVE_NUM-1:0] e_ready_i,
    output DATA_T                e_bits_o,
    output logic                 err_o,
    input  logic                 err_clr_i,
    output logic [15:0]          drop_cnt_o
);

    localparam int unsigned ROUTE_W = SINK_MSB - SINK_LSB;
    localparam int unsigned CNT_W   = 16;
    localparam logic        DropEn  = (DROP_UNMAPPED != 0);

    if (SINK_MSB <= SINK_LSB || SLAVE_NUM > (1 << ROUTE_W)) begin : gen_param_err
        $error("tl_sink_router_e: bad SINK_MSB/SINK_LSB/SLAVE_NUM combination");
    end

    function automatic logic [SLAVE_NUM-1:0] decode(input logic [ROUTE_W-1:0] idx,
                                                    input logic mapped);
        logic [SLAVE_NUM-1:0] sel;
        sel = '0;
        for (int k = 0; k < SLAVE_NUM; k++) begin
            sel[k] = mapped && (idx == ROUTE_W'(k));
        end
        return sel;
    endfunction

    logic [ROUTE_W-1:0] in_idx;
    logic               in_mapped;

    assign in_idx    = e_bits_i.sink[SINK_MSB-1:SINK_LSB];
    assign in_mapped = (32'(in_idx) < SLAVE_NUM);

    if (PIPE != 0) begin : gen_pipe
        typedef struct packed {
            DATA_T              bits;
            logic [ROUTE_W-1:0] idx;
            logic               mapped;
        } entry_t;

        entry_t               in_entry, out_entry;
        logic                 spill_valid, spill_ready, out_valid, out_ready;
        logic [SLAVE_NUM-1:0] out_sel;

        assign in_entry    = '{bits: e_bits_i, idx: in_idx, mapped: in_mapped};
        // Without drop, unmapped beats are never enqueued and stall upstream.
        assign spill_valid = e_valid_i & (in_mapped | DropEn);
        assign e_ready_o   = spill_ready & (in_mapped | DropEn);

        tl_spill_reg #(
            .T(entry_t)
        ) u_spill (
            .clk_i  (clk_i),
            .rst_i  (rst_i),
            .valid_i(spill_valid),
            .ready_o(spill_ready),
            .data_i (in_entry),
            .valid_o(out_valid),
            .ready_i(out_ready),
            .data_o (out_entry)
        );

        assign out_sel   = decode(out_entry.idx, out_entry.mapped);
        assign e_valid_o = out_valid ? out_sel : '0;
        // Unmapped entries drain on their own without any slave seeing them.
        assign out_ready = out_entry.mapped ? |(out_sel & e_ready_i) : 1'b1;
        assign e_bits_o  = out_entry.bits;
    end else begin : gen_comb
        logic [SLAVE_NUM-1:0] in_sel;

        assign in_sel    = decode(in_idx, in_mapped);
        assign e_valid_o = e_valid_i ? in_sel : '0;
        assign e_ready_o = in_mapped ? |(in_sel & e_ready_i) : DropEn;
        assign e_bits_o  = e_bits_i;
    end

    logic             err_q, err_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
    logic             pres_q, pres_d;
    logic             unmapped_in, cnt_evt;

    assign unmapped_in = e_valid_i & ~in_mapped;
    // A stalled unmapped beat is counted once, on its first presented cycle.
    assign cnt_evt     = DropEn ? (unmapped_in & e_ready_o) : (unmapped_in & ~pres_q);
    assign pres_d      = unmapped_in;

    always_comb begin
        err_d      = err_q | cnt_evt;
        drop_cnt_d = drop_cnt_q;
        if (cnt_evt && (drop_cnt_q != {CNT_W{1'b1}})) begin
            drop_cnt_d = drop_cnt_q + 1'b1;
        end
        if (err_clr_i) begin
            err_d      = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            err_q      <= 1'b0;
            drop_cnt_q <= '0;
            pres_q     <= 1'b0;
        end else begin
            err_q      <= err_d;
            drop_cnt_q <= drop_cnt_d;
            pres_q     <= pres_d;
        end
    end

    assign err_o      = err_q;
    assign drop_cnt_o = drop_cnt_q;

endmodule

// File: tb/tb_tl_sink_router_e.sv
module tb_tl_sink_router_e;
    import tl_pkg::*;

    logic clk = 1'b0;
    logic rst_i;
    always #5 clk = ~clk;

    // Main instance: SLAVE_NUM=4, PIPE=1, DROP_UNMAPPED=1
    logic        e_valid_i, e_ready_o, err_o, err_clr_i;
    tl_e_t       e_bits_i, e_bits_o;
    logic [3:0]  e_valid_o, e_ready_i;
    logic [15:0] drop_cnt_o;

    // Second instance: DROP_UNMAPPED=0
    logic        b_valid_i, b_ready_o, b_err_o, b_err_clr_i;
    tl_e_t       b_bits_i, b_bits_o;
    logic [3:0]  b_valid_o, b_ready_i;
    logic [15:0] b_drop_cnt_o;

    tl_sink_router_e #(
        .SLAVE_NUM(4), .SINK_LSB(2), .SINK_MSB(5), .PIPE(1), .DROP_UNMAPPED(1),
        .DATA_T(tl_e_t)
    ) dut (
        .clk_i(clk), .rst_i(rst_i), .e_valid_i(e_valid_i), .e_ready_o(e_ready_o),
        .e_bits_i(e_bits_i), .e_valid_o(e_valid_o), .e_ready_i(e_ready_i),
        .e_bits_o(e_bits_o), .err_o(err_o), .err_clr_i(err_clr_i), .drop_cnt_o(drop_cnt_o)
    );

    tl_sink_router_e #(
        .SLAVE_NUM(4), .SINK_LSB(2), .SINK_MSB(5), .PIPE(1), .DROP_UNMAPPED(0),
        .DATA_T(tl_e_t)
    ) dut_nodrop (
        .clk_i(clk), .rst_i(rst_i), .e_valid_i(b_valid_i), .e_ready_o(b_ready_o),
        .e_bits_i(b_bits_i), .e_valid_o(b_valid_o), .e_ready_i(b_ready_i),
        .e_bits_o(b_bits_o), .err_o(b_err_o), .err_clr_i(b_err_clr_i),
        .drop_cnt_o(b_drop_cnt_o)
    );

    int vectors = 0;
    int miscompares = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference model: beats to mapped slaves leave in arrival order; unmapped ones
    // only bump the sticky flag and saturating counter.
    typedef struct {
        int         idx;
        logic [7:0] sink;
    } exp_t;

    exp_t exp_q[$];
    logic m_err = 1'b0;
    int   m_cnt = 0;
    bit   mon_en = 1'b0;

    always @(negedge clk) begin
        if (rst_i && mon_en) begin
            int idx;
            check("err_o", 32'(err_o), 32'(m_err));
            check("drop_cnt", 32'(drop_cnt_o), 32'(m_cnt));
            check("onehot0", 32'($onehot0(e_valid_o)), 32'd1);
            if (|e_valid_o) begin
                if (exp_q.size() == 0) begin
                    check("spurious_valid", 32'(e_valid_o), 32'd0);
                end else begin
                    check("route", 32'(e_valid_o), 32'd1 << exp_q[0].idx);
                    check("payload", 32'(e_bits_o.sink), 32'(exp_q[0].sink));
                    if (|(e_valid_o & e_ready_i)) void'(exp_q.pop_front());
                end
            end
            if (e_valid_i && e_ready_o) begin
                idx = int'(e_bits_i.sink) / 4 % 8;
                if (idx < 4) begin
                    exp_q.push_back('{idx: idx, sink: e_bits_i.sink});
                end else begin
                    m_err = 1'b1;
                    if (m_cnt < 65535) m_cnt++;
                end
            end
            if (err_clr_i) begin
                m_err = 1'b0;
                m_cnt = 0;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Hold the current beat until accepted, bounded.
    task automatic wait_acc(input string nm);
        bit acc = 1'b0;
        int n = 0;
        while (!acc && n < 50) begin
            @(negedge clk);
            acc = e_ready_o;
            tick();
            n++;
        end
        check(nm, 32'(acc), 32'd1);
    endtask

    initial begin
        rst_i = 1'b0;
        e_valid_i = 1'b0; e_bits_i = '0; e_ready_i = 4'hF; err_clr_i = 1'b0;
        b_valid_i = 1'b0; b_bits_i = '0; b_ready_i = 4'hF; b_err_clr_i = 1'b0;

        // Reset state
        repeat (3) tick();
        @(negedge clk);
        check("rst_valid", 32'(e_valid_o), 32'd0);
        check("rst_ready", 32'(e_ready_o), 32'd0);
        check("rst_err", 32'(err_o), 32'd0);
        check("rst_cnt", 32'(drop_cnt_o), 32'd0);
        tick();
        rst_i = 1'b1;
        @(negedge clk);
        tick();
        @(negedge clk);
        check("ready_after_rst", 32'(e_ready_o), 32'd1);
        mon_en = 1'b1;
        tick();

        // Single beat, one-cycle latency
        e_valid_i = 1'b1; e_bits_i.sink = 8'h08;
        wait_acc("acc_08");
        e_valid_i = 1'b0;
        @(negedge clk);
        check("lat_valid", 32'(e_valid_o), 32'b0100);
        check("lat_bits", 32'(e_bits_o.sink), 32'h08);
        tick();

        // Back-to-back, no bubbles
        e_valid_i = 1'b1; e_bits_i.sink = 8'h00;
        @(negedge clk); check("b2b_rdy0", 32'(e_ready_o), 32'd1);
        tick(); e_bits_i.sink = 8'h04;
        @(negedge clk); check("b2b_v0", 32'(e_valid_o), 32'b0001);
        check("b2b_rdy1", 32'(e_ready_o), 32'd1);
        tick(); e_bits_i.sink = 8'h0C;
        @(negedge clk); check("b2b_v1", 32'(e_valid_o), 32'b0010);
        check("b2b_rdy2", 32'(e_ready_o), 32'd1);
        tick(); e_valid_i = 1'b0;
        @(negedge clk); check("b2b_v2", 32'(e_valid_o), 32'b1000);
        tick();

        // Stalled slave 1: backpressure after two entries, payload stable
        e_ready_i = 4'b1101;
        e_valid_i = 1'b1; e_bits_i.sink = 8'h04;
        @(negedge clk); check("stall_rdy0", 32'(e_ready_o), 32'd1);
        tick(); e_bits_i.sink = 8'h05;
        @(negedge clk); check("stall_rdy1", 32'(e_ready_o), 32'd1);
        tick(); e_bits_i.sink = 8'h26;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("stall_rdy_low", 32'(e_ready_o), 32'd0);
            check("stall_hold_v", 32'(e_valid_o), 32'b0010);
            check("stall_hold_bits", 32'(e_bits_o.sink), 32'h04);
            tick();
        end
        e_ready_i = 4'hF;
        wait_acc("stall_acc3");
        e_valid_i = 1'b0;
        repeat (5) tick();

        // Unmapped beat dropped, then clear wins over a same-cycle drop
        e_valid_i = 1'b1; e_bits_i.sink = 8'h14;
        wait_acc("acc_14");
        e_valid_i = 1'b0;
        @(negedge clk);
        check("drop_novalid", 32'(e_valid_o), 32'd0);
        check("drop_err", 32'(err_o), 32'd1);
        check("drop_cnt1", 32'(drop_cnt_o), 32'd1);
        tick();
        e_valid_i = 1'b1; e_bits_i.sink = 8'h1C; err_clr_i = 1'b1;
        wait_acc("acc_1c");
        e_valid_i = 1'b0; err_clr_i = 1'b0;
        @(negedge clk);
        check("clr_err", 32'(err_o), 32'd0);
        check("clr_cnt", 32'(drop_cnt_o), 32'd0);
        check("clr_novalid", 32'(e_valid_o), 32'd0);
        tick();

        // Randomized traffic against the scoreboard
        for (int c = 0; c < 600; c++) begin
            bit acc;
            @(negedge clk);
            acc = e_valid_i & e_ready_o;
            tick();
            if (!e_valid_i || acc) begin
                e_valid_i = ($urandom_range(0, 9) < 7);
                e_bits_i.sink = 8'($urandom_range(0, 255));
            end
            e_ready_i = 4'($urandom);
            err_clr_i = ($urandom_range(0, 19) == 0);
        end
        @(negedge clk);
        tick();
        e_valid_i = 1'b0; e_ready_i = 4'hF; err_clr_i = 1'b0;
        repeat (10) tick();
        check("drain_empty", 32'(exp_q.size()), 32'd0);

        // Counter saturation under continuous unmapped traffic
        e_valid_i = 1'b1; e_bits_i.sink = 8'h18;
        repeat (65540) @(posedge clk);
        #1;
        e_valid_i = 1'b0;
        @(negedge clk);
        check("sat_cnt", 32'(drop_cnt_o), 32'hFFFF);
        check("sat_err", 32'(err_o), 32'd1);
        tick();

        // Reset with two buffered beats discards them
        e_ready_i = 4'h0;
        e_valid_i = 1'b1; e_bits_i.sink = 8'h00;
        wait_acc("buf_acc0");
        e_bits_i.sink = 8'h04;
        wait_acc("buf_acc1");
        e_valid_i = 1'b0;
        mon_en = 1'b0;
        rst_i = 1'b0;
        exp_q.delete(); m_err = 1'b0; m_cnt = 0;
        @(posedge clk);
        @(negedge clk);
        check("mrst_valid", 32'(e_valid_o), 32'd0);
        check("mrst_ready", 32'(e_ready_o), 32'd0);
        check("mrst_cnt", 32'(drop_cnt_o), 32'd0);
        tick();
        rst_i = 1'b1; e_ready_i = 4'hF;
        @(posedge clk);
        @(negedge clk);
        check("mrst_ready_rel", 32'(e_ready_o), 32'd1);
        for (int i = 0; i < 3; i++) begin
            check("mrst_novalid", 32'(e_valid_o), 32'd0);
            @(negedge clk);
        end
        tick();
        mon_en = 1'b1;

        // No-drop instance: unmapped beat stalls forever, counted once
        b_valid_i = 1'b1; b_bits_i.sink = 8'h1C;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("nd_ready_low", 32'(b_ready_o), 32'd0);
            check("nd_novalid", 32'(b_valid_o), 32'd0);
            tick();
        end
        @(negedge clk);
        check("nd_cnt_once", 32'(b_drop_cnt_o), 32'd1);
        check("nd_err", 32'(b_err_o), 32'd1);
        tick();
        b_valid_i = 1'b0;
        tick();
        b_valid_i = 1'b1; b_bits_i.sink = 8'h08;
        @(negedge clk);
        check("nd_map_ready", 32'(b_ready_o), 32'd1);
        tick();
        b_valid_i = 1'b0;
        @(negedge clk);
        check("nd_map_valid", 32'(b_valid_o), 32'b0100);
        check("nd_map_bits", 32'(b_bits_o.sink), 32'h08);
        check("nd_cnt_after", 32'(b_drop_cnt_o), 32'd1);
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
